ctrl_datapath: RTL and testbench
================================

# ctrl_datapath

Register-file/ALU datapath driven by the control word `{clr, sel, w, s, ce}` that the lab FSM controller emits each cycle. It holds four WIDTH-bit registers R0..R3 and performs one ALU operation per cycle. It writes the result into any subset of registers selected by `ce`. It exposes R3 and registered status flags back to the controller and the bench.

## Interface
- WIDTH, 8, data path width in bits (≥ 4).

- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear of R0..R3 and the flags.
- sel  input  2  A-operand source: 0 = din, 1 = R0, 2 = R1, 3 = R2.
- w    input  3  shift amount for shift ops.
- s    input  3  ALU op select.
- ce   input  4  write enables; bit i loads R{i}.
- din  input  WIDTH  external data operand.
- res  output WIDTH  combinational ALU result for the current cycle.
- dout output WIDTH  current R3 contents.
- z    output 1  registered zero flag.
- c    output 1  registered carry/borrow flag.

## Operation
- Operand A = mux(sel) per the port list; operand B is always R3.
- ALU ops by `s`:
  - 0: pass A
  - 1: A+B
  - 2: A−B
  - 3: A&B
  - 4: A|B
  - 5: A^B
  - 6: A<<w
  - 7: A>>w (logical).
- Arithmetic is modulo 2^WIDTH, computed at WIDTH+1 bits.
- Carry flag:
  - Add: carry out.
  - Sub: borrow, 1 when A < B unsigned.
  - Ops 0, 3, 4, 5, 6, 7: 0.
- Shifts: w = 0 yields A unchanged. If w ≥ WIDTH, the result is 0.
- Register write: on a clock edge with clr = 0, every R{i} with ce[i] = 1 loads res. All other registers hold. Any combination of ce bits is legal, including 4'hF.
- Flags: when clr = 0 and ce ≠ 0, z ← (res == 0) and c ← computed carry. When ce = 0, the flags hold.
- clr has priority over ce: if clr = 1, R0..R3, z and c are all 0 on the next edge, regardless of ce, s and sel.
- No internal FSM sequencing. All sequencing comes from the controller, so every cycle is independent apart from register state.

## Timing
- Reset:
  - While rst = 0, R0..R3, z and c are 0, asynchronously and immediately, mid-cycle included. As a result, dout = 0.
  - Outputs update in the same cycle rst falls.
- Release: the first capture occurs on the first rising edge with rst = 1.
- `res` is combinational: it is valid in the same cycle as the control word and din, within one clock period.
- Write latency is 1 cycle. A value written at edge N is visible on dout/res (as an operand) after edge N.
- Read-modify-write in one cycle is legal. For example, sel = 1 with ce = 4'b0001 updates R0 from its own old value; R3 used as both B and destination uses the old R3.
- Flags are registered. They reflect the op performed at the most recent enabled edge, not the current `res`.

## Test plan
- Reset:
  - Preload R0..R3 = 8'hAA.
  - Drop rst mid-cycle: R0..R3, dout, z and c are 0 before the next edge.
  - Hold rst = 0 across edges with ce = 4'hF: registers stay 0.
- Load/pass:
  - clr = 1 for 1 cycle.
  - Then din = 8'h05, sel = 0, s = 0, ce = 4'b0001: R0 = 8'h05, z = 0, c = 0.
  - Then sel = 1, ce = 4'b1000: dout = 8'h05.
- Add with carry:
  - Setup: R0 = 8'hF0, R3 = 8'h20.
  - sel = 1, s = 1, ce = 4'b1000: dout = 8'h10, c = 1, z = 0.
  - Then ce = 0 with a different s: z and c hold.
- Subtract:
  - A = din = 8'h03, R3 = 8'h05, s = 2, ce = 4'b0010: R1 = 8'hFE, c = 1.
  - A = 8'h05 (din), ce = 4'b0010: R1 = 8'h00, z = 1, c = 0.
- Shifts and logic:
  - A = 8'h81, w = 4, s = 6: res = 8'h10.
  - s = 7: res = 8'h08.
  - w = 0: res = 8'h81.
  - Also with A = 8'h81: s = 3 with R3 = 8'h0F gives 8'h01; s = 5 gives 8'h8E.
- Priority/simultaneity:
  - clr = 1 with ce = 4'hF and s = 1: all registers and flags are 0.
  - ce = 4'b0111 with din = 8'h3C, sel = 0, s = 0: R0 = R1 = R2 = 8'h3C, R3 unchanged.

Source files
------------

// File: rtl/ctrl_datapath_if.sv
// Control-word and data bus between the lab FSM controller and the register-file/ALU datapath.
// The controller drives the master side; the datapath implements the slave side.
interface ctrl_datapath_if #(
    parameter int WIDTH = 8
);
    logic             clr;
    logic [1:0]       sel;
    logic [2:0]       w;
    logic [2:0]       s;
    logic [3:0]       ce;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] dout;
    logic             z;
    logic             c;

    modport master (
        output clr, sel, w, s, ce, din,
        input  res, dout, z, c
    );

    modport slave (
        input  clr, sel, w, s, ce, din,
        output res, dout, z, c
    );
endinterface

// File: rtl/ctrl_datapath.sv
// Four-register file with a single-cycle ALU, executing one control word per clock.
// Result can be written to any subset of R0..R3; zero/carry flags are captured on enabled writes.
module ctrl_datapath #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    ctrl_datapath_if.slave  bus
);

    logic [WIDTH-1:0] regs_r [4];
    logic             z_r;
    logic             c_r;

    logic [WIDTH-1:0] opa_s;
    logic [WIDTH:0]   alu_s;
    logic [WIDTH-1:0] res_s;
    logic             carry_s;

    // Returns {carry, result}; subtraction at WIDTH+1 bits leaves the borrow in the top bit.
    function automatic logic [WIDTH:0] alu_f(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [2:0]       sh
    );
        logic [WIDTH:0] r;
        logic           sh_over;
        r       = {(WIDTH+1){1'b0}};
        sh_over = ({29'd0, sh} >= WIDTH);
        case (op)
            3'd0:    r = {1'b0, a};
            3'd1:    r = {1'b0, a} + {1'b0, b};
            3'd2:    r = {1'b0, a} - {1'b0, b};
            3'd3:    r = {1'b0, a & b};
            3'd4:    r = {1'b0, a | b};
            3'd5:    r = {1'b0, a ^ b};
            3'd6:    r = sh_over ? {(WIDTH+1){1'b0}} : {1'b0, a << sh};
            3'd7:    r = sh_over ? {(WIDTH+1){1'b0}} : {1'b0, a >> sh};
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    // Operand A selection and ALU evaluation for the current control word.
    always_comb begin
        opa_s = bus.din;
        case (bus.sel)
            2'd0:    opa_s = bus.din;
            2'd1:    opa_s = regs_r[0];
            2'd2:    opa_s = regs_r[1];
            2'd3:    opa_s = regs_r[2];
            default: opa_s = bus.din;
        endcase
        alu_s   = alu_f(bus.s, opa_s, regs_r[3], bus.w);
        res_s   = alu_s[WIDTH-1:0];
        carry_s = alu_s[WIDTH];
    end

    // Register file and flag capture; clr outranks any write enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
            z_r <= 1'b0;
            c_r <= 1'b0;
        end else if (bus.clr) begin
            for (int i = 0; i < 4; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
            z_r <= 1'b0;
            c_r <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bus.ce[i]) begin
                    regs_r[i] <= res_s;
                end
            end
            if (bus.ce != 4'b0000) begin
                z_r <= (res_s == {WIDTH{1'b0}});
                c_r <= carry_s;
            end
        end
    end

    assign bus.res  = res_s;
    assign bus.dout = regs_r[3];
    assign bus.z    = z_r;
    assign bus.c    = c_r;

endmodule

// File: tb/tb_ctrl_datapath.sv
// Randomized and directed bench for ctrl_datapath against an integer-arithmetic register-file model.
// A negedge compare process checks res/dout/z/c every cycle; directed literals pin the model.
module tb_ctrl_datapath;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nvec  = 0;
    int   nfail = 0;

    int unsigned m_reg [4] = '{0, 0, 0, 0};
    int unsigned m_z = 0;
    int unsigned m_c = 0;

    ctrl_datapath_if #(.WIDTH(W)) bus ();

    ctrl_datapath #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected result and carry from the arithmetic definitions of each op.
    function automatic int unsigned model_opa();
        int unsigned a;
        if (bus.sel == 2'd0) a = int'(bus.din);
        else a = m_reg[int'(bus.sel) - 1];
        return a;
    endfunction

    function automatic int unsigned model_res();
        int unsigned a, b, sh;
        a  = model_opa();
        b  = m_reg[3];
        sh = int'(bus.w);
        case (int'(bus.s))
            0: return a;
            1: return (a + b) % 256;
            2: return (a + 256 - b) % 256;
            3: return a & b;
            4: return a | b;
            5: return a ^ b;
            6: return (sh >= W) ? 0 : (a * (1 << sh)) % 256;
            7: return (sh >= W) ? 0 : a / (1 << sh);
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned model_carry();
        int unsigned a, b;
        a = model_opa();
        b = m_reg[3];
        if (bus.s == 3'd1) return (a + b > 255) ? 1 : 0;
        if (bus.s == 3'd2) return (a < b) ? 1 : 0;
        return 0;
    endfunction

    task automatic model_edge();
        int unsigned r, cy;
        if (bus.clr) begin
            for (int i = 0; i < 4; i++) m_reg[i] = 0;
            m_z = 0;
            m_c = 0;
        end else begin
            r  = model_res();
            cy = model_carry();
            for (int i = 0; i < 4; i++) if (bus.ce[i]) m_reg[i] = r;
            if (bus.ce != 4'b0000) begin
                m_z = (r == 0) ? 1 : 0;
                m_c = cy;
            end
        end
    endtask

    always @(negedge rst) begin
        for (int i = 0; i < 4; i++) m_reg[i] = 0;
        m_z = 0;
        m_c = 0;
    end

    // Per-cycle compare of every observable output against the model.
    always @(negedge clk) begin
        cmp("res",  32'(bus.res),  model_res());
        cmp("dout", 32'(bus.dout), m_reg[3]);
        cmp("z",    32'(bus.z),    m_z);
        cmp("c",    32'(bus.c),    m_c);
    end

    task automatic step(input logic clr_v, input logic [1:0] sel_v, input logic [2:0] w_v,
                        input logic [2:0] s_v, input logic [3:0] ce_v, input logic [7:0] din_v);
        bus.clr = clr_v;
        bus.sel = sel_v;
        bus.w   = w_v;
        bus.s   = s_v;
        bus.ce  = ce_v;
        bus.din = din_v;
        @(posedge clk);
        if (rst) model_edge();
        #1;
    endtask

    task automatic peek(input string nm, input logic [1:0] sel_v, input logic [2:0] w_v,
                        input logic [2:0] s_v, input logic [7:0] din_v, input logic [7:0] exp);
        bus.clr = 1'b0;
        bus.ce  = 4'b0000;
        bus.sel = sel_v;
        bus.w   = w_v;
        bus.s   = s_v;
        bus.din = din_v;
        #1;
        cmp(nm, 32'(bus.res), 32'(exp));
    endtask

    initial begin
        bus.clr = 1'b0; bus.sel = 2'd0; bus.w = 3'd0; bus.s = 3'd0;
        bus.ce = 4'b0000; bus.din = 8'h00;

        // Reset held across edges with writes requested
        step(1'b0, 2'd0, 3'd0, 3'd0, 4'hF, 8'hAA);
        step(1'b0, 2'd0, 3'd0, 3'd0, 4'hF, 8'hAA);
        cmp("rst_hold_dout", 32'(bus.dout), 32'h0);
        rst = 1'b1;

        // Preload, then drop reset mid-cycle
        step(1'b0, 2'd0, 3'd0, 3'd0, 4'hF, 8'hAA);
        cmp("preload_dout", 32'(bus.dout), 32'hAA);
        #2 rst = 1'b0;
        #1;
        cmp("async_dout", 32'(bus.dout), 32'h0);
        cmp("async_z", 32'(bus.z), 32'h0);
        cmp("async_c", 32'(bus.c), 32'h0);
        peek("async_r0", 2'd1, 3'd0, 3'd0, 8'h00, 8'h00);
        peek("async_r1", 2'd2, 3'd0, 3'd0, 8'h00, 8'h00);
        peek("async_r2", 2'd3, 3'd0, 3'd0, 8'h00, 8'h00);
        step(1'b0, 2'd0, 3'd0, 3'd0, 4'hF, 8'hAA);
        step(1'b0, 2'd0, 3'd0, 3'd0, 4'hF, 8'hAA);
        cmp("rst_hold2_dout", 32'(bus.dout), 32'h0);
        rst = 1'b1;

        // Load / pass
        step(1'b1, 2'd0, 3'd0, 3'd0, 4'b0000, 8'h00);
        step(1'b0, 2'd0, 3'd0, 3'd0, 4'b0001, 8'h05);
        cmp("load_z", 32'(bus.z), 32'h0);
        cmp("load_c", 32'(bus.c), 32'h0);
        step(1'b0, 2'd1, 3'd0, 3'd0, 4'b1000, 8'h00);
        cmp("pass_dout", 32'(bus.dout), 32'h05);

        // Add with carry, then flags hold on ce = 0
        step(1'b0, 2'd0, 3'd0, 3'd0, 4'b0001, 8'hF0);
        step(1'b0, 2'd0, 3'd0, 3'd0, 4'b1000, 8'h20);
        step(1'b0, 2'd1, 3'd0, 3'd1, 4'b1000, 8'h00);
        cmp("add_dout", 32'(bus.dout), 32'h10);
        cmp("add_c", 32'(bus.c), 32'h1);
        cmp("add_z", 32'(bus.z), 32'h0);
        step(1'b0, 2'd1, 3'd0, 3'd5, 4'b0000, 8'h00);
        cmp("hold_c", 32'(bus.c), 32'h1);
        cmp("hold_z", 32'(bus.z), 32'h0);

        // Subtract with borrow, then to zero
        step(1'b0, 2'd0, 3'd0, 3'd0, 4'b1000, 8'h05);
        step(1'b0, 2'd0, 3'd0, 3'd2, 4'b0010, 8'h03);
        cmp("sub_c", 32'(bus.c), 32'h1);
        peek("sub_r1", 2'd2, 3'd0, 3'd0, 8'h00, 8'hFE);
        step(1'b0, 2'd0, 3'd0, 3'd2, 4'b0010, 8'h05);
        cmp("sub0_z", 32'(bus.z), 32'h1);
        cmp("sub0_c", 32'(bus.c), 32'h0);
        peek("sub0_r1", 2'd2, 3'd0, 3'd0, 8'h00, 8'h00);

        // Shifts and logic on A = 0x81
        step(1'b0, 2'd0, 3'd0, 3'd0, 4'b1000, 8'h0F);
        peek("shl4", 2'd0, 3'd4, 3'd6, 8'h81, 8'h10);
        peek("shr4", 2'd0, 3'd4, 3'd7, 8'h81, 8'h08);
        peek("shl0", 2'd0, 3'd0, 3'd6, 8'h81, 8'h81);
        peek("shr0", 2'd0, 3'd0, 3'd7, 8'h81, 8'h81);
        peek("and",  2'd0, 3'd0, 3'd3, 8'h81, 8'h01);
        peek("xor",  2'd0, 3'd0, 3'd5, 8'h81, 8'h8E);

        // clr priority over a full write
        step(1'b1, 2'd1, 3'd0, 3'd1, 4'hF, 8'h77);
        cmp("clr_dout", 32'(bus.dout), 32'h0);
        cmp("clr_z", 32'(bus.z), 32'h0);
        cmp("clr_c", 32'(bus.c), 32'h0);

        // Multi-register write leaves R3 alone
        step(1'b0, 2'd0, 3'd0, 3'd0, 4'b1000, 8'h55);
        step(1'b0, 2'd0, 3'd0, 3'd0, 4'b0111, 8'h3C);
        cmp("multi_dout", 32'(bus.dout), 32'h55);
        peek("multi_r0", 2'd1, 3'd0, 3'd0, 8'h00, 8'h3C);
        peek("multi_r1", 2'd2, 3'd0, 3'd0, 8'h00, 8'h3C);
        peek("multi_r2", 2'd3, 3'd0, 3'd0, 8'h00, 8'h3C);

        // Randomized control words against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
